// File: rtl/led_demap_if.sv
// rtl/led_demap_if.sv - LED/switch word in, decoded result out, valid/ready handshake
//
// Signals:
//   led_in     raw 16-bit group word from the board bus, may bounce
//   out_ready  consumer accepts the result while out_valid is high
//   out_valid  pos/patt/err hold a decoded result
//   pos        recovered 3-bit position code
//   patt       recovered 4-bit pattern
//   err        word is not a legal group mapping
//   busy       demapper is settling, decoding or holding a result
//
// Modports:
//   master  side that drives led_in/out_ready and consumes the result
//   slave   the demapper itself
interface led_demap_if;
    logic [15:0] led_in;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  pos;
    logic [3:0]  patt;
    logic        err;
    logic        busy;

    modport master (
        output led_in,
        output out_ready,
        input  out_valid,
        input  pos,
        input  patt,
        input  err,
        input  busy
    );

    modport slave (
        input  led_in,
        input  out_ready,
        output out_valid,
        output pos,
        output patt,
        output err,
        output busy
    );
endinterface

// File: rtl/led_demap.sv
// rtl/led_demap.sv - debounced inverse of the LED group mapper
//
// Watches a 16-bit word of four 4-bit groups (g1=[15:12] .. g4=[3:0]), waits
// until it has been stable for STABLE_CYCLES consecutive samples, then decodes
// the position code and pattern and presents them once through valid/ready.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   led_demap_if.slave: led_in, out_ready in; out_valid, pos, patt,
//         err, busy out
//
// Parameters:
//   STABLE_CYCLES  matching samples required before decode (>= 1)
//   CNT_W          stability counter width, must hold STABLE_CYCLES-1
module led_demap #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic         clk,
    input  logic         rst,
    led_demap_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECODE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [15:0]      samp_q,      samp_d;
    logic [15:0]      last_word_q, last_word_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       pos_q,       pos_d;
    logic [3:0]       patt_q,      patt_d;
    logic             err_q,       err_d;

    // ------------------------------------------------------------------
    // Combinational decode of the sampled word
    // ------------------------------------------------------------------
    logic [3:0] g1, g2, g3, g4;
    logic [3:0] mask;
    logic [3:0] common;
    logic       groups_equal;
    logic       mask_legal;
    logic [2:0] mask_pos;
    logic       dec_err;
    logic [2:0] dec_pos;
    logic [3:0] dec_patt;

    always_comb begin
        g1 = samp_q[15:12];
        g2 = samp_q[11:8];
        g3 = samp_q[7:4];
        g4 = samp_q[3:0];

        mask = {g1 != 4'h0, g2 != 4'h0, g3 != 4'h0, g4 != 4'h0};

        // If every nonzero group carries the same value, OR-ing all groups
        // reproduces that value; any disagreement shows up as a nonzero
        // group that differs from the OR.
        common       = g1 | g2 | g3 | g4;
        groups_equal = ((g1 == 4'h0) || (g1 == common)) &&
                       ((g2 == 4'h0) || (g2 == common)) &&
                       ((g3 == 4'h0) || (g3 == common)) &&
                       ((g4 == 4'h0) || (g4 == common));

        mask_legal = 1'b1;
        mask_pos   = 3'd0;
        case (mask)
            4'b1100: mask_pos = 3'd0;
            4'b1010: mask_pos = 3'd1;
            4'b1001: mask_pos = 3'd2;
            4'b0110: mask_pos = 3'd3;
            4'b0101: mask_pos = 3'd4;
            4'b0011: mask_pos = 3'd5;
            4'b1110: mask_pos = 3'd6;
            4'b0111: mask_pos = 3'd7;
            default: mask_legal = 1'b0;
        endcase

        // An all-zero word lands in the default branch as mask 0000.
        dec_err  = !(mask_legal && groups_equal);
        dec_pos  = dec_err ? 3'd0 : mask_pos;
        dec_patt = dec_err ? 4'h0 : common;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        samp_d      = bus.led_in;
        last_word_d = last_word_q;
        out_valid_d = out_valid_q;
        pos_d       = pos_q;
        patt_d      = patt_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                // A word equal to the last reported one is never re-reported.
                if (samp_q != last_word_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end

            ST_SETTLE: begin
                // led_in is the sample about to be taken; a difference means
                // the word is still bouncing and the count starts over.
                if (bus.led_in != samp_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                pos_d       = dec_pos;
                patt_d      = dec_patt;
                err_d       = dec_err;
                out_valid_d = 1'b1;
                last_word_d = samp_q;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                // Result stays frozen until the consumer takes it.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            samp_q      <= 16'h0000;
            last_word_q <= 16'h0000;
            out_valid_q <= 1'b0;
            pos_q       <= 3'd0;
            patt_q      <= 4'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            last_word_q <= last_word_d;
            out_valid_q <= out_valid_d;
            pos_q       <= pos_d;
            patt_q      <= patt_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.pos       = pos_q;
    assign bus.patt      = patt_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_demap.sv
// tb/tb_led_demap.sv - testbench for led_demap
module tb_led_demap;

    logic clk;
    logic rst;

    led_demap_if bus();

    led_demap #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] word;
        logic        e_err;
        logic [2:0]  e_pos;
        logic [3:0]  e_patt;
        int          rdy_delay;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference decode written from the mapping rules: collect the nonzero
    // groups, look their position mask up in the list of legal masks and
    // require all of them to carry one value.
    function automatic void model_decode(input logic [15:0] w, output logic e,
                                         output logic [2:0] p, output logic [3:0] t);
        int legal[8] = '{12, 10, 9, 6, 5, 3, 14, 7};
        int m;
        int found;
        logic [3:0] vals[$];
        logic [3:0] g;
        logic same;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            g = 4'((w >> (12 - 4 * i)) & 16'h000F);
            if (g != 4'h0) begin
                vals.push_back(g);
                m = m + (1 << (3 - i));
            end
        end
        found = -1;
        for (int k = 0; k < 8; k++)
            if (legal[k] == m) found = k;
        same = 1'b1;
        foreach (vals[k])
            if (vals[k] != vals[0]) same = 1'b0;
        if (found < 0 || !same) begin
            e = 1'b1; p = 3'd0; t = 4'h0;
        end else begin
            e = 1'b0; p = 3'(found); t = vals[0];
        end
    endfunction

    // Drives a word from IDLE, measures latency, checks the result, applies
    // optional backpressure and completes the handshake.
    task automatic run_word(input logic [15:0] w, input logic e_err, input logic [2:0] e_pos,
                            input logic [3:0] e_patt, input int rdy_delay, input string tag);
        int   n;
        logic stable;
        bus.led_in    = w;
        bus.out_ready = (rdy_delay == 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 20);
        check($sformatf("%s latency", tag), 32'(n), 32'd7);
        check($sformatf("%s valid", tag), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s err", tag), 32'(bus.err), 32'(e_err));
        check($sformatf("%s pos", tag), 32'(bus.pos), 32'(e_pos));
        check($sformatf("%s patt", tag), 32'(bus.patt), 32'(e_patt));
        check($sformatf("%s busy", tag), 32'(bus.busy), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < rdy_delay; i++) begin
            tick();
            if (!bus.out_valid || bus.pos !== e_pos || bus.patt !== e_patt || bus.err !== e_err)
                stable = 1'b0;
        end
        if (rdy_delay > 0)
            check($sformatf("%s held", tag), 32'(stable), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check($sformatf("%s drop", tag), 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int          n;
        int          pulses;
        logic        stable;
        logic [2:0]  cap_pos;
        logic [3:0]  cap_patt;
        logic        cap_err;
        logic [15:0] prev;
        logic [15:0] w;
        logic        me;
        logic [2:0]  mp;
        logic [3:0]  mt;

        vecs[0]  = '{16'hAA00, 1'b0, 3'd0, 4'hA, 0};
        vecs[1]  = '{16'h5050, 1'b0, 3'd1, 4'h5, 0};
        vecs[2]  = '{16'h0707, 1'b0, 3'd4, 4'h7, 2};
        vecs[3]  = '{16'h0777, 1'b0, 3'd7, 4'h7, 0};
        vecs[4]  = '{16'hCCC0, 1'b0, 3'd6, 4'hC, 0};
        vecs[5]  = '{16'hA0B0, 1'b1, 3'd0, 4'h0, 0};
        vecs[6]  = '{16'hFFFF, 1'b1, 3'd0, 4'h0, 3};
        vecs[7]  = '{16'h3300, 1'b0, 3'd0, 4'h3, 0};
        vecs[8]  = '{16'h0000, 1'b1, 3'd0, 4'h0, 0};
        vecs[9]  = '{16'h000F, 1'b1, 3'd0, 4'h0, 0};
        vecs[10] = '{16'hF0FF, 1'b1, 3'd0, 4'h0, 0};
        vecs[11] = '{16'h0F0F, 1'b0, 3'd4, 4'hF, 1};
        vecs[12] = '{16'h0880, 1'b0, 3'd3, 4'h8, 0};
        vecs[13] = '{16'h9009, 1'b0, 3'd2, 4'h9, 0};

        // Reset state
        rst           = 1'b1;
        bus.led_in    = 16'h0000;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset pos", 32'(bus.pos), 32'd0);
        check("reset patt", 32'(bus.patt), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven words
        for (int i = 0; i < 14; i++)
            run_word(vecs[i].word, vecs[i].e_err, vecs[i].e_pos, vecs[i].e_patt,
                     vecs[i].rdy_delay, $sformatf("vec%0d_%04h", i, vecs[i].word));

        // Bounce between two words, then settle on the second
        pulses = 0; cap_pos = 3'd0; cap_patt = 4'h0; cap_err = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.led_in = (k % 2 == 0) ? 16'h3300 : 16'h3030;
            repeat (2) begin
                tick();
                if (bus.out_valid) pulses++;
            end
        end
        bus.led_in = 16'h3030;
        repeat (30) begin
            tick();
            if (bus.out_valid) begin
                pulses++;
                cap_pos = bus.pos; cap_patt = bus.patt; cap_err = bus.err;
            end
        end
        check("bounce pulses", 32'(pulses), 32'd1);
        check("bounce pos", 32'(cap_pos), 32'd1);
        check("bounce patt", 32'(cap_patt), 32'd3);
        check("bounce err", 32'(cap_err), 32'd0);

        // Backpressure: result held while the input moves on
        bus.out_ready = 1'b0;
        bus.led_in    = 16'h9900;
        n = 0;
        do begin tick(); n++; end while (!bus.out_valid && n < 20);
        check("bp first valid", 32'(bus.out_valid), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) bus.led_in = 16'h0099;
            tick();
            if (!bus.out_valid || bus.pos !== 3'd0 || bus.patt !== 4'h9 || bus.err !== 1'b0)
                stable = 1'b0;
        end
        check("bp held stable", 32'(stable), 32'd1);
        check("bp busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp drop", 32'(bus.out_valid), 32'd0);
        n = 0;
        do begin tick(); n++; end while (!bus.out_valid && n < 20);
        check("bp second valid", 32'(bus.out_valid), 32'd1);
        check("bp second pos", 32'(bus.pos), 32'd5);
        check("bp second patt", 32'(bus.patt), 32'd9);
        check("bp second err", 32'(bus.err), 32'd0);
        tick();
        check("bp second drop", 32'(bus.out_valid), 32'd0);

        // Same word held long after its handshake
        pulses = 0;
        repeat (100) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        check("no repeat pulses", 32'(pulses), 32'd0);
        check("no repeat busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of settling
        bus.led_in = 16'h0550;
        repeat (3) tick();
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(bus.out_valid), 32'd0);
        check("async rst pos", 32'(bus.pos), 32'd0);
        check("async rst patt", 32'(bus.patt), 32'd0);
        check("async rst err", 32'(bus.err), 32'd0);
        check("async rst busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_word(16'h0550, 1'b0, 3'd3, 4'h5, 0, "after_reset");
        prev = 16'h0550;

        // Randomised words against the reference model
        for (int i = 0; i < 40; i++) begin
            do begin
                if ($urandom_range(0, 1) == 0) begin
                    w = 16'h0000;
                    mt = 4'($urandom_range(1, 15));
                    case ($urandom_range(0, 7))
                        0: w = {mt, mt, 4'h0, 4'h0};
                        1: w = {mt, 4'h0, mt, 4'h0};
                        2: w = {mt, 4'h0, 4'h0, mt};
                        3: w = {4'h0, mt, mt, 4'h0};
                        4: w = {4'h0, mt, 4'h0, mt};
                        5: w = {4'h0, 4'h0, mt, mt};
                        6: w = {mt, mt, mt, 4'h0};
                        default: w = {4'h0, mt, mt, mt};
                    endcase
                end else begin
                    w = 16'($urandom);
                end
            end while (w == prev);
            model_decode(w, me, mp, mt);
            run_word(w, me, mp, mt, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                     $sformatf("rand%0d_%04h", i, w));
            prev = w;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
